fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch front end for the RV64 subset core (add/sub/and/or/addi/ld/sd/beq).
//  Owns the PC, reads the word-addressed instruction memory, and buffers {pc, insn} pairs
//  in a small prefetch FIFO. Feeds decode over a valid/ready handshake.
//  Decode/execute redirects fetch on taken beq. An all-zero word halts fetch.
// PARAMETERS
//  XLEN      64  PC / address width
//  IMEM_AW   5   instruction memory word-address width (32 words)
//  DEPTH     2   prefetch FIFO entries; power of two, >=2
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk             in   1        single clock, all state updates on posedge
//  reset           in   1        synchronous, active-high
//  imem_addr       out  IMEM_AW  word index = pc[IMEM_AW+1:2]
//  imem_rdata      in   32       combinational read data for imem_addr (same cycle)
//  out_valid       out  1        FIFO head holds a valid instruction
//  out_ready       in   1        decode accepts head this cycle
//  out_insn        out  32       head instruction
//  out_pc          out  XLEN     head PC
//  redirect_valid  in   1        taken branch: discard buffered work, refetch
//  redirect_pc     in   XLEN     branch target
//  halted          out  1        fetch stopped after an all-zero word
// BEHAVIOUR
//  Reset:
//   - pc=RESET_PC, FIFO empty, halted=0.
//   - Outputs after reset: out_valid=0, out_insn=0, out_pc=0, imem_addr=RESET_PC[IMEM_AW+1:2].
//  Fetch:
//   - fetch_en = !halted && !redirect_valid && (!full || pop).
//   - When fetch_en: push {pc, imem_rdata}, then pc <= pc+4 (wraps mod 2^XLEN).
//   - Latency: 1 cycle. A word fetched in cycle N is on out_* in cycle N+1 if the FIFO was empty.
//  Pop:
//   - pop = out_valid && out_ready.
//   - Push and pop in the same cycle are allowed while full: count unchanged, no word lost.
//   - out_insn/out_pc are 0 whenever out_valid=0.
//  Redirect (highest priority, above pop and push):
//   - Flush every FIFO entry, including a head handshaked in the same cycle; that head counts as not consumed.
//   - pc <= {redirect_pc[XLEN-1:2],2'b00}, halted <= 0, no push that cycle.
//  Halt:
//   - If the fetched word is 32'h0 and fetch_en: push it, then halted <= 1. No further imem reads are used.
//   - The zero word is delivered to decode in order, so downstream sees the terminator.
//  Out of range:
//   - If pc[XLEN-1:IMEM_AW+2] != 0, the fetched word is forced to 32'h0, which halts fetch.
//   - This covers an index wrap past the last word.
//  Reset mid-operation: behaves exactly like power-up reset, with no residual FIFO entries.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   - Adds 32-bit outputs perf_cycles, perf_fetched, perf_stall.
//   - All three clear on reset.
//   - perf_cycles: +1 every cycle with reset=0 && !halted.
//   - perf_fetched: +1 per push.
//   - perf_stall: +1 when !halted && full && !pop.
//   - All three saturate at 32'hFFFF_FFFF.
//  PERF_CNT_EN undefined: the ports and counters do not exist. Fetch behaviour is identical.
// STRUCTURE
//  Package riscv_pkg:
//   - XLEN.
//   - Opcode localparams OP_R=7'b0110011, OP_I=7'b0010011, OP_LD=7'b0000011, OP_SD=7'b0100011,
//     OP_BEQ=7'b1100011.
//   - HALT_INSN=32'h0.
//   - fetch_pkt_t struct {pc, insn}.
//  Sub-module fetch_fifo:
//   - Parameterised DEPTH, width = XLEN+32.
//   - Ports: push, pop, flush, full, empty, head.
//   - Wrap-around pointers with an extra MSB for full/empty detection.
//  fetch_stage contains the PC register, halt flag, imem address generation and priority logic.
// TESTING
//  1. imem[0]=0x00F00093, imem[1]=0x01900113; reset 2 cycles, out_ready=1
//     -> cycle 1 after reset: out_valid=1, out_pc=0, out_insn=0x00F00093; next cycle out_pc=4.
//  2. out_ready=0 for 6 cycles from reset -> exactly DEPTH pushes, then imem_addr holds at DEPTH;
//     out_ready=1 -> out_pc 0,4,8,... consecutive, none lost or duplicated.
//  3. FIFO full (pc 0,4 buffered), redirect_valid=1 with redirect_pc=0x30 and out_ready=1 same cycle
//     -> next valid out_pc=0x30; 0 and 4 never accepted.
//  4. imem[3]=0 -> word with out_pc=0xC, out_insn=0 delivered; halted=1 from the next cycle;
//     out_valid=0 once drained; redirect to 0 -> halted=0, fetch resumes at 0.
//  5. redirect_pc=0x7C, imem[31] nonzero -> out_pc=0x7C delivered; next pc=0x80 is out of range
//     -> insn 0 at out_pc=0x80, halted=1.
//  6. Reset asserted mid-stream with FIFO full -> next cycle out_valid=0, halted=0, imem_addr=0;
//     with PERF_CNT_EN, all counters=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV64 subset core front end.
package riscv_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [31:0] HALT_INSN = 32'h0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, insn} packets; wrap-around pointers with an extra MSB.
// Flush has priority over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = $bits(riscv_pkg::fetch_pkt_t)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, imem addressing, halt flag and prefetch FIFO.
// Optional PERF_CNT_EN adds saturating cycle/fetch/stall counters.
module fetch_stage #(
    parameter int          XLEN     = riscv_pkg::XLEN,
    parameter int          IMEM_AW  = 5,
    parameter int          DEPTH    = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_insn,
    output logic [XLEN-1:0]    out_pc,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               halted
`ifdef PERF_CNT_EN
   ,output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);
    import riscv_pkg::*;

    logic [XLEN-1:0]    r_pc;
    logic               r_halted;

    logic               w_full;
    logic               w_empty;
    logic [XLEN+31:0]   w_head;
    logic               w_hs;
    logic               w_pop;
    logic               w_push;
    logic               w_oor;
    logic [31:0]        w_insn;
    logic [XLEN-1:0]    w_redirect_aligned;

    assign imem_addr = r_pc[IMEM_AW+1:2];
    assign w_oor     = |r_pc[XLEN-1:IMEM_AW+2];
    assign w_insn    = w_oor ? HALT_INSN : imem_rdata;

    // Redirect wins: a head handshaked in the redirect cycle is not consumed.
    assign w_hs   = !w_empty && out_ready;
    assign w_pop  = w_hs && !redirect_valid;
    assign w_push = !r_halted && !redirect_valid && (!w_full || w_hs);

    assign w_redirect_aligned = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= XLEN'(RESET_PC);
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= w_redirect_aligned;
            r_halted <= 1'b0;
        end else if (w_push) begin
            r_pc <= r_pc + XLEN'(4);
            if (w_insn == HALT_INSN) begin
                r_halted <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (XLEN + 32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({r_pc, w_insn}),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign out_valid = !w_empty;
    assign out_pc    = out_valid ? w_head[XLEN+31:32] : '0;
    assign out_insn  = out_valid ? w_head[31:0] : '0;
    assign halted    = r_halted;

`ifdef PERF_CNT_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_cycles  <= '0;
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (!r_halted && r_perf_cycles != 32'hFFFF_FFFF) begin
                r_perf_cycles <= r_perf_cycles + 1'b1;
            end
            if (w_push && r_perf_fetched != 32'hFFFF_FFFF) begin
                r_perf_fetched <= r_perf_fetched + 1'b1;
            end
            if (!r_halted && w_full && !w_hs && r_perf_stall != 32'hFFFF_FFFF) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized redirect/backpressure runs.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam int BXLEN   = 64;
    localparam int IMEM_AW = 5;
    localparam int DEPTH   = 2;
    localparam int W       = BXLEN + 32;

    logic               clk = 1'b0;
    logic               reset;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_insn;
    logic [BXLEN-1:0]   out_pc;
    logic               redirect_valid;
    logic [BXLEN-1:0]   redirect_pc;
    logic               halted;
`ifdef PERF_CNT_EN
    logic [31:0]        perf_cycles;
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_stall;
`endif

    logic [31:0] imem [32];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_pkt;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr];

    fetch_stage #(
        .XLEN     (BXLEN),
        .IMEM_AW  (IMEM_AW),
        .DEPTH    (DEPTH),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_insn       (out_insn),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef PERF_CNT_EN
       ,.perf_cycles    (perf_cycles),
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // The program stream seen by decode: words in order from the start PC
    // up to and including the first zero word (out of range reads as zero).
    function automatic void build_stream(input logic [BXLEN-1:0] start);
        fetch_pkt_t p;
        logic [BXLEN-1:0] pc;
        logic [31:0] word;
        exp_q.delete();
        pc = start & ~64'h3;
        for (int n = 0; n < 40; n++) begin
            word = (pc < 64'h80) ? imem[pc[6:2]] : 32'h0;
            p.pc = pc;
            p.insn = word;
            exp_q.push_back(p);
            if (word == 32'h0) break;
            pc = pc + 64'd4;
        end
    endfunction

    // Monitor: checks every accepted head against the expected stream.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (!out_valid) begin
                check("idle_outputs_zero", {out_pc, out_insn}, '0);
            end else if (out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got pc=%h insn=%h want nothing", out_pc, out_insn);
                end else begin
                    exp_pkt = exp_q.pop_front();
                    check("stream_word", {out_pc, out_insn}, exp_pkt);
                    if (out_insn == 32'h0) check("halted_with_terminator", W'(halted), W'(1));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        redirect_valid = 1'b0;
        build_stream(64'h0);
        repeat (n) tick();
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_halted", W'(halted), W'(0));
        check("reset_imem_addr", W'(imem_addr), W'(0));
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [BXLEN-1:0] pc, input logic ready);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        out_ready = ready;
        build_stream(pc);
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic drain(input bit rand_ready, input int budget);
        int i;
        i = 0;
        while (i < budget && !(exp_q.size() == 0 && halted && !out_valid)) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            i++;
        end
        checks++;
        if (!(exp_q.size() == 0 && halted && !out_valid)) begin
            failures++;
            $display("FAIL drain: got pending=%0d halted=%0b out_valid=%0b want 0/1/0",
                     exp_q.size(), halted, out_valid);
        end
        out_ready = 1'b1;
    endtask

    function automatic void fill_imem(input int zero_odds);
        for (int k = 0; k < 32; k++) begin
            imem[k] = ($urandom_range(0, zero_odds) == 0) ? 32'h0 : ($urandom() | 32'h1);
        end
    endfunction

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        fill_imem(1000000);
        imem[0] = 32'h00F00093;
        imem[1] = 32'h01900113;

        // First word after reset, then the next one.
        do_reset(2);
        check("t1_cycle0_valid", W'(out_valid), W'(0));
        tick();
        check("t1_first_word", {W'(out_valid), out_pc, out_insn}, {W'(1), 64'h0, 32'h00F00093});
        tick();
        check("t1_second_pc", W'(out_pc), W'(64'h4));
        drain(1'b0, 100);

        // Backpressure from reset: exactly DEPTH pushes, then fetch stalls.
        out_ready = 1'b0;
        do_reset(1);
        repeat (6) tick();
        check("t2_imem_addr_hold", W'(imem_addr), W'(DEPTH));
        check("t2_head", {W'(out_valid), out_pc}, {W'(1), 64'h0});
        drain(1'b0, 100);

        // Redirect while full, with a same-cycle handshake that must be discarded.
        out_ready = 1'b0;
        do_reset(1);
        repeat (3) tick();
        check("t3_full_addr", W'(imem_addr), W'(2));
        do_redirect(64'h30, 1'b1);
        check("t3_flushed", W'(out_valid), W'(0));
        tick();
        check("t3_target_head", {W'(out_valid), out_pc}, {W'(1), 64'h30});
        drain(1'b0, 100);

        // Zero word halts, is delivered, and a redirect resumes fetch.
        imem[3] = 32'h0;
        out_ready = 1'b1;
        do_reset(1);
        drain(1'b0, 50);
        repeat (3) tick();
        check("t4_still_halted", W'({halted, out_valid}), W'(2'b10));
        do_redirect(64'h0, 1'b1);
        check("t4_resumed", W'(halted), W'(0));
        drain(1'b0, 50);
        imem[3] = 32'h12345677;

        // Last word then wrap out of range.
        imem[31] = 32'hCAFE0013;
        do_redirect(64'h7C, 1'b1);
        drain(1'b0, 50);

        // Reset mid-stream with the FIFO full.
        out_ready = 1'b0;
        do_reset(1);
        repeat (4) tick();
        reset = 1'b1;
        build_stream(64'h0);
        tick();
        check("t6_valid", W'(out_valid), W'(0));
        check("t6_halted", W'(halted), W'(0));
        check("t6_imem_addr", W'(imem_addr), W'(0));
`ifdef PERF_CNT_EN
        check("t6_perf", {perf_cycles, perf_fetched, perf_stall}, '0);
`endif
        reset = 1'b0;
        drain(1'b0, 100);

        // Randomized programs, backpressure and redirects.
        for (int it = 0; it < 20; it++) begin
            fill_imem(15);
            do_redirect(64'($urandom_range(0, 40) * 4 + $urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 19) == 0) begin
                    do_redirect(64'($urandom_range(0, 40) * 4 + $urandom_range(0, 3)),
                                1'($urandom_range(0, 1)));
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            drain(1'b1, 400);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
